// File: rtl/ddr3_app_port_if.sv
// ddr3_app_port_if: request/response bus between a memory client (master) and ddr3_app_port (slave)
//   req_valid/req_ready  request handshake; req_we, req_addr, req_wdata, req_wmask qualify it
//   rsp_valid/rsp_ready  response handshake; rsp_rdata, rsp_we qualify it
interface ddr3_app_port_if #(
    parameter int ADDR_W = 24
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [127:0]      req_wdata;
    logic [15:0]       req_wmask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_we;
    logic [127:0]      rsp_rdata;
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_we, rsp_rdata
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_we, rsp_rdata
    );
endinterface

// File: rtl/ddr3_app_port.sv
// ddr3_app_port: single-outstanding adapter from a valid/ready word port to the Gowin DDR3 app interface
//   clk, rst                 controller user clock, synchronous active-high reset
//   init_calib_complete_i    controller calibration done
//   bus (slave)              request/response handshake bus
//   app_*_o / app_*_i        controller command, write-data and read-return channels (one BL8 burst per request)
//   busy_o                   not in READY
//   timeout_err_o            sticky read-timeout flag, cleared only by rst
module ddr3_app_port #(
    parameter int ADDR_W     = 24,
    parameter int RD_TIMEOUT = 1023
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           init_calib_complete_i,
    ddr3_app_port_if.slave bus,
    output logic [5:0]     app_burst_number_o,
    output logic [26:0]    app_addr_o,
    output logic           app_cmd_en_o,
    input  logic           app_cmd_rdy_i,
    output logic [2:0]     app_cmd_o,
    output logic           app_wdata_en_o,
    input  logic           app_wdata_rdy_i,
    output logic           app_wdata_end_o,
    output logic [127:0]   app_wdata_o,
    output logic [15:0]    app_wdata_mask_o,
    input  logic           app_rdata_valid_i,
    input  logic           app_rdata_end_i,
    input  logic [127:0]   app_rdata_i,
    output logic           busy_o,
    output logic           timeout_err_o
);
    typedef enum logic [2:0] {INIT, READY, WR, RD_CMD, RD_WAIT, RSP} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [127:0]      wdata_q, wdata_d, rdata_q, rdata_d;
    logic [15:0]       mask_q, mask_d;
    logic              cmd_done_q, cmd_done_d, wd_done_q, wd_done_d, toerr_q, toerr_d;
    logic [9:0]        cnt_q, cnt_d;
    assign bus.req_ready      = state_q == READY && init_calib_complete_i;
    assign bus.rsp_valid      = state_q == RSP;
    assign bus.rsp_we         = we_q;
    assign bus.rsp_rdata      = rdata_q;
    // cmd and data channels of a write retire independently; each enable drops once its beat is taken
    assign app_cmd_en_o       = (state_q == WR && !cmd_done_q) || state_q == RD_CMD;
    assign app_wdata_en_o     = state_q == WR && !wd_done_q;
    assign app_wdata_end_o    = app_wdata_en_o;
    assign app_cmd_o          = state_q == RD_CMD ? 3'b001 : 3'b000;
    assign app_burst_number_o = '0;
    assign app_addr_o         = 27'({addr_q, 3'b000});
    assign app_wdata_o        = wdata_q;
    assign app_wdata_mask_o   = mask_q;
    assign busy_o             = state_q != READY;
    assign timeout_err_o      = toerr_q;
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        mask_d     = mask_q;
        rdata_d    = rdata_q;
        toerr_d    = toerr_q;
        cnt_d      = '0;
        cmd_done_d = cmd_done_q || (app_cmd_en_o && app_cmd_rdy_i);
        wd_done_d  = wd_done_q || (app_wdata_en_o && app_wdata_rdy_i);
        case (state_q)
            INIT:    state_d = init_calib_complete_i ? READY : INIT;
            READY: begin
                if (bus.req_valid && bus.req_ready) begin
                    addr_d     = bus.req_addr;
                    we_d       = bus.req_we;
                    wdata_d    = bus.req_wdata;
                    mask_d     = ~bus.req_wmask;
                    rdata_d    = '0;
                    cmd_done_d = 1'b0;
                    wd_done_d  = 1'b0;
                    state_d    = bus.req_we ? WR : RD_CMD;
                end else if (!init_calib_complete_i) begin
                    state_d = INIT;
                end
            end
            WR:      state_d = cmd_done_q && wd_done_q ? RSP : WR;
            RD_CMD:  state_d = app_cmd_rdy_i ? RD_WAIT : RD_CMD;
            RD_WAIT: begin
                if (app_rdata_valid_i && app_rdata_end_i) begin
                    rdata_d = app_rdata_i;
                    state_d = RSP;
                end else if (cnt_q == 10'(RD_TIMEOUT - 1)) begin
                    // no beat arrived: answer with zero data rather than hang; a late beat lands outside RD_WAIT and is dropped
                    toerr_d = 1'b1;
                    state_d = RSP;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            RSP:     state_d = !bus.rsp_ready ? RSP : init_calib_complete_i ? READY : INIT;
            default: state_d = INIT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            mask_q     <= '0;
            rdata_q    <= '0;
            toerr_q    <= 1'b0;
            cnt_q      <= '0;
            cmd_done_q <= 1'b0;
            wd_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            mask_q     <= mask_d;
            rdata_q    <= rdata_d;
            toerr_q    <= toerr_d;
            cnt_q      <= cnt_d;
            cmd_done_q <= cmd_done_d;
            wd_done_q  <= wd_done_d;
        end
    end
endmodule
